// File: rtl/mac_port_table.sv
// mac_port_table
// ---------------------------------------------------------------------------
// Destination-MAC forwarding lookup shared by P_PORT_NUM receive channels,
// with a source-MAC learning port.
//
// Each channel owns one pending slot (mac + id). A round-robin arbiter
// grants at most one slot per cycle. Each grant enters a fixed three-stage
// lookup:
//   G   : grant; the granted mac and id are registered
//   G+1 : parallel compare against every valid entry; the result is registered
//   G+2 : o_result_valid pulses with o_check_id / o_seek_flag / o_outport
// A request strobed on an idle block therefore replies three cycles later.
//
// Ports
//   i_clk, i_rst       core clock; synchronous active-low reset
//   i_check_mac/_id    packed per-channel request (channel k at [48k+47:48k] / [4k+3:4k])
//   i_check_valid      per-channel 1-cycle request strobe
//   i_learn_mac/_port  source MAC and its ingress port
//   i_learn_valid      1-cycle learn strobe
//   o_outport          egress port of the reply (4'hF on a miss)
//   o_result_valid     1-cycle reply strobe, broadcast to all channels
//   o_check_id         id of the replied request
//   o_seek_flag        1 = hit, 0 = miss
//   o_req_drop         pulses when a pending, ungranted slot is overwritten
//   o_entry_cnt        number of valid table entries
//
// Build option
//   MAC_AGING_EN  when defined, entries age out after P_AGE_MAX ticks of
//                 P_AGE_TICK cycles each unless they are refreshed by a learn.
// ---------------------------------------------------------------------------
module mac_port_table #(
    parameter int         P_PORT_NUM = 4,
    parameter int         P_DEPTH    = 16,
    parameter int         P_AGE_TICK = 156250000,
    parameter logic [2:0] P_AGE_MAX  = 3'd5
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [48*P_PORT_NUM-1:0]  i_check_mac,
    input  logic [4*P_PORT_NUM-1:0]   i_check_id,
    input  logic [P_PORT_NUM-1:0]     i_check_valid,
    input  logic [47:0]               i_learn_mac,
    input  logic [3:0]                i_learn_port,
    input  logic                      i_learn_valid,
    output logic [3:0]                o_outport,
    output logic                      o_result_valid,
    output logic [3:0]                o_check_id,
    output logic                      o_seek_flag,
    output logic                      o_req_drop,
    output logic [$clog2(P_DEPTH):0]  o_entry_cnt
);

    localparam int AW = $clog2(P_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (P_PORT_NUM > 1) ? $clog2(P_PORT_NUM) : 1;

    // ---------------- request slots and arbiter ----------------
    logic [P_PORT_NUM-1:0] pend_vld_q;
    logic [47:0]           pend_mac_q [P_PORT_NUM];
    logic [3:0]            pend_id_q  [P_PORT_NUM];
    // rr_q holds the first channel to examine, i.e. one past the last grant.
    logic [PW-1:0]         rr_q;
    logic [PW-1:0]         rr_d;
    logic [PW-1:0]         rr_cand;
    logic                  gnt_vld;
    logic [PW-1:0]         gnt_idx;
    logic [P_PORT_NUM-1:0] gnt_mask;
    logic                  drop_d;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_cand = '0;
        for (int i = 0; i < P_PORT_NUM; i++) begin
            rr_cand = PW'((int'(rr_q) + i) % P_PORT_NUM);
            if (!gnt_vld && pend_vld_q[rr_cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_cand;
            end
        end
    end

    assign gnt_mask = gnt_vld ? (P_PORT_NUM'(1) << gnt_idx) : '0;
    assign rr_d     = PW'((int'(gnt_idx) + 1) % P_PORT_NUM);
    // A slot granted this cycle is vacated at the same edge, so a new strobe
    // on that channel is a plain refill rather than an overwrite.
    assign drop_d   = |(i_check_valid & pend_vld_q & ~gnt_mask);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pend_vld_q <= '0;
            rr_q       <= '0;
            for (int k = 0; k < P_PORT_NUM; k++) begin
                pend_mac_q[k] <= '0;
                pend_id_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < P_PORT_NUM; k++) begin
                if (i_check_valid[k]) begin
                    pend_vld_q[k] <= 1'b1;
                    pend_mac_q[k] <= i_check_mac[48*k +: 48];
                    pend_id_q[k]  <= i_check_id[4*k +: 4];
                end else if (gnt_mask[k]) begin
                    pend_vld_q[k] <= 1'b0;
                end
            end
            if (gnt_vld) begin
                rr_q <= rr_d;
            end
        end
    end

    // ---------------- table storage ----------------
    logic [P_DEPTH-1:0] ent_vld_q;
    logic [P_DEPTH-1:0] vld_d;
    logic [47:0]        ent_mac_q  [P_DEPTH];
    logic [3:0]         ent_port_q [P_DEPTH];
    logic [AW-1:0]      repl_q;
    logic [CW-1:0]      cnt_d;

    // ---------------- lookup pipeline ----------------
    logic        s1_vld_q;
    logic [47:0] s1_mac_q;
    logic [3:0]  s1_id_q;
    logic        cmp_hit;
    logic [AW-1:0] cmp_idx;
    logic        res_vld_q;
    logic [3:0]  res_id_q;
    logic        seek_q;
    logic [3:0]  port_q;
    logic        drop_q;
    logic [CW-1:0] cnt_q;

    // Lowest matching index wins; a group-address destination never hits.
    always_comb begin
        cmp_hit = 1'b0;
        cmp_idx = '0;
        for (int i = 0; i < P_DEPTH; i++) begin
            if (!cmp_hit && ent_vld_q[i] && (ent_mac_q[i] == s1_mac_q)) begin
                cmp_hit = 1'b1;
                cmp_idx = AW'(i);
            end
        end
        if (s1_mac_q[40]) begin
            cmp_hit = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            s1_vld_q  <= 1'b0;
            s1_mac_q  <= '0;
            s1_id_q   <= '0;
            res_vld_q <= 1'b0;
            res_id_q  <= '0;
            seek_q    <= 1'b0;
            port_q    <= '0;
            drop_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_vld_q  <= gnt_vld;
            s1_mac_q  <= pend_mac_q[gnt_idx];
            s1_id_q   <= pend_id_q[gnt_idx];
            res_vld_q <= s1_vld_q;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
            if (s1_vld_q) begin
                res_id_q <= s1_id_q;
                seek_q   <= cmp_hit;
                port_q   <= cmp_hit ? ent_port_q[cmp_idx] : 4'hF;
            end
        end
    end

    assign o_result_valid = res_vld_q;
    assign o_check_id     = res_id_q;
    assign o_seek_flag    = seek_q;
    assign o_outport      = port_q;
    assign o_req_drop     = drop_q;
    assign o_entry_cnt    = cnt_q;

    // ---------------- learning ----------------
    logic          l_en;
    logic          l_hit;
    logic [AW-1:0] l_hit_idx;
    logic          l_free;
    logic [AW-1:0] l_free_idx;
    logic [AW-1:0] l_idx;

    // Group addresses and the all-zero address are never learned.
    assign l_en = i_learn_valid && !i_learn_mac[40] && (i_learn_mac != 48'd0);

    always_comb begin
        l_hit      = 1'b0;
        l_hit_idx  = '0;
        l_free     = 1'b0;
        l_free_idx = '0;
        for (int i = 0; i < P_DEPTH; i++) begin
            if (!l_hit && ent_vld_q[i] && (ent_mac_q[i] == i_learn_mac)) begin
                l_hit     = 1'b1;
                l_hit_idx = AW'(i);
            end
            if (!l_free && !ent_vld_q[i]) begin
                l_free     = 1'b1;
                l_free_idx = AW'(i);
            end
        end
        l_idx = l_hit ? l_hit_idx : (l_free ? l_free_idx : repl_q);
    end

`ifdef MAC_AGING_EN
    logic [31:0] tick_cnt_q;
    logic        age_tick;
    logic [2:0]  age_q [P_DEPTH];
    logic [2:0]  age_d [P_DEPTH];

    assign age_tick = (tick_cnt_q == 32'(P_AGE_TICK - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            tick_cnt_q <= '0;
            for (int i = 0; i < P_DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            tick_cnt_q <= age_tick ? 32'd0 : tick_cnt_q + 32'd1;
            age_q      <= age_d;
        end
    end
`else
    logic unused_age_cfg;
    assign unused_age_cfg = ^{P_AGE_MAX, 32'(P_AGE_TICK)};
`endif

    // Next valid vector: aging first, then the learn write, so a learn that
    // lands on an expiring entry keeps it alive.
    always_comb begin
        vld_d = ent_vld_q;
`ifdef MAC_AGING_EN
        age_d = age_q;
        if (age_tick) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                if (ent_vld_q[i]) begin
                    age_d[i] = age_q[i] - 3'd1;
                    if (age_q[i] <= 3'd1) begin
                        vld_d[i] = 1'b0;
                    end
                end
            end
        end
`endif
        if (l_en) begin
            vld_d[l_idx] = 1'b1;
`ifdef MAC_AGING_EN
            age_d[l_idx] = P_AGE_MAX;
`endif
        end
        cnt_d = '0;
        for (int i = 0; i < P_DEPTH; i++) begin
            cnt_d = cnt_d + CW'(vld_d[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ent_vld_q <= '0;
            repl_q    <= '0;
            for (int i = 0; i < P_DEPTH; i++) begin
                ent_mac_q[i]  <= '0;
                ent_port_q[i] <= '0;
            end
        end else begin
            ent_vld_q <= vld_d;
            if (l_en) begin
                ent_mac_q[l_idx]  <= i_learn_mac;
                ent_port_q[l_idx] <= i_learn_port;
            end
            // Replacement pointer only moves when a full table evicts an entry.
            if (l_en && !l_hit && !l_free) begin
                repl_q <= repl_q + AW'(1);
            end
        end
    end

endmodule
